// File: rtl/alu_wide_seq.sv
// alu_wide_seq: 16-bit add/sub/shift-by-one sequencer that drives an 8-bit ALU over LO, HI and FIX passes
module alu_wide_seq #(
  parameter logic [7:0] OP_ADD = 8'h00,
  parameter logic [7:0] OP_SUB = 8'h01,
  parameter logic [7:0] OP_LSL = 8'h05,
  parameter logic [7:0] OP_LSR = 8'h06,
  parameter logic [7:0] OP_OR  = 8'h03
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [1:0]  wop_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [7:0]  alu_rs_o,
  output logic [7:0]  alu_rt_o,
  output logic [8:0]  alu_op_o,
  input  logic [7:0]  alu_res_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        carry_o
);
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;
  state_t state;
  logic [15:0] a_q, b_q;
  logic [1:0] wop_q;
  logic [7:0] lo_q, hi_q;
  logic c0_q, c1_q, av, bv, c_pass, fix_c;
  function automatic logic [7:0] pass_op(input logic [1:0] w);
    return w == 2'b00 ? OP_ADD : w == 2'b01 ? OP_SUB : w == 2'b10 ? OP_LSL : OP_LSR;
  endfunction
  always_comb begin
    av = state == HI ? a_q[15] : a_q[7];
    bv = state == HI ? b_q[15] : b_q[7];
    c_pass = wop_q[0] ? (~av & bv) | ((~av | bv) & alu_res_i[7])
                      : (av & bv) | ((av | bv) & ~alu_res_i[7]);
    fix_c = wop_q == 2'b00 ? c1_q | (&hi_q & c0_q) :
            wop_q == 2'b01 ? c1_q | (~|hi_q & c0_q) :
            wop_q == 2'b10 ? a_q[15] : a_q[0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      wop_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
      alu_rs_o <= '0;
      alu_rt_o <= '0;
      alu_op_o <= {OP_OR, 1'b0};
      busy_o <= 1'b0;
      done_o <= 1'b0;
      result_o <= '0;
      carry_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= LO;
          a_q <= a_i;
          b_q <= b_i;
          wop_q <= wop_i;
          busy_o <= 1'b1;
          alu_rs_o <= a_i[7:0];
          alu_rt_o <= wop_i[1] ? 8'd1 : b_i[7:0];
          alu_op_o <= {pass_op(wop_i), 1'b0};
        end
        LO: begin
          state <= HI;
          lo_q <= alu_res_i;
          c0_q <= c_pass;
          alu_rs_o <= a_q[15:8];
          alu_rt_o <= wop_q[1] ? 8'd1 : b_q[15:8];
        end
        HI: begin
          state <= FIX;
          hi_q <= alu_res_i;
          c1_q <= c_pass;
          alu_rs_o <= wop_q == 2'b11 ? lo_q : alu_res_i;
          alu_rt_o <= wop_q == 2'b11 ? {a_q[8], 7'b0} : wop_q == 2'b10 ? {7'b0, a_q[7]} : {7'b0, c0_q};
          alu_op_o <= {wop_q[1] ? OP_OR : pass_op(wop_q), 1'b0};
        end
        FIX: begin
          state <= DONE;
          result_o <= wop_q == 2'b11 ? {hi_q, alu_res_i} : {alu_res_i, lo_q};
          carry_o <= fix_c;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          alu_rs_o <= '0;
          alu_rt_o <= '0;
          alu_op_o <= {OP_OR, 1'b0};
        end
        default: begin
          state <= IDLE;
          done_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: directed checks of the 16-bit ALU sequencer against a behavioural 8-bit ALU
module tb_alu_wide_seq;
  localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_LSL = 8'h05, OP_LSR = 8'h06, OP_OR = 8'h03;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, busy, done, carry;
  logic [1:0] wop = '0;
  logic [15:0] a_in = '0, b_in = '0, result;
  logic [7:0] alu_rs, alu_rt, alu_res;
  logic [8:0] alu_op;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  always_comb begin
    alu_res = alu_op[8:1] == OP_ADD ? alu_rs + alu_rt :
              alu_op[8:1] == OP_SUB ? alu_rs - alu_rt :
              alu_op[8:1] == OP_LSL ? alu_rs << alu_rt :
              alu_op[8:1] == OP_LSR ? alu_rs >> alu_rt :
              alu_op[8:1] == OP_OR  ? alu_rs | alu_rt : 8'h00;
  end
  alu_wide_seq #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_LSL(OP_LSL), .OP_LSR(OP_LSR), .OP_OR(OP_OR)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .wop_i(wop), .a_i(a_in), .b_i(b_in),
    .alu_rs_o(alu_rs), .alu_rt_o(alu_rt), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .busy_o(busy), .done_o(done), .result_o(result), .carry_o(carry));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [15:0] er, input logic ec);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    chk({tag, "_rs"}, 32'(alu_rs), 32'd0);
    chk({tag, "_rt"}, 32'(alu_rt), 32'd0);
    chk({tag, "_op"}, 32'(alu_op), 32'({OP_OR, 1'b0}));
  endtask
  task automatic run_op(input string tag, input logic [1:0] w, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic ec);
    @(negedge clk);
    start = 1'b1; wop = w; a_in = a; b_in = b;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busyoff"}, 32'(busy), 32'd0);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_idle("reset", 16'h0000, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1 chk_idle("idle", 16'h0000, 1'b0);
    run_op("add_lo_carry", 2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
    run_op("add_wrap",     2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    run_op("add_hi_carry", 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    run_op("add_plain",    2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0);
    run_op("sub_borrow_lo",2'b01, 16'h0100, 16'h0001, 16'h00FF, 1'b0);
    run_op("sub_wrap",     2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    run_op("sub_neg",      2'b01, 16'h1234, 16'h4321, 16'hCF13, 1'b1);
    run_op("lsl_cross",    2'b10, 16'h80C0, 16'h0000, 16'h0180, 1'b1);
    run_op("lsl_plain",    2'b10, 16'h1234, 16'hFFFF, 16'h2468, 1'b0);
    run_op("lsr_cross",    2'b11, 16'h0181, 16'h0000, 16'h00C0, 1'b1);
    run_op("lsr_plain",    2'b11, 16'h1234, 16'hFFFF, 16'h091A, 1'b0);
    @(negedge clk);
    start = 1'b1; wop = 2'b00; a_in = 16'h0001; b_in = 16'h0001;
    @(posedge clk); #1 wop = 2'b01; a_in = 16'hFFFF;
    chk("ign_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1 chk("ign_busy2", 32'(busy), 32'd1);
    @(posedge clk); #1 chk("ign_busy3", 32'(busy), 32'd1);
    start = 1'b0;
    @(posedge clk); #1 chk("ign_done", 32'(done), 32'd1);
    chk("ign_res", 32'(result), 32'h0002);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk_idle("ign_after", 16'h0002, 1'b0);
    end
    @(negedge clk);
    start = 1'b1; wop = 2'b00; a_in = 16'h0F0F; b_in = 16'h0101;
    @(posedge clk); #1 start = 1'b0;
    chk("rst_held_res", 32'(result), 32'h0002);
    @(posedge clk); #1 chk("rst_in_hi", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1 chk_idle("rst_async", 16'h0000, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk_idle("rst_nodone", 16'h0000, 1'b0);
    end
    run_op("post_rst", 2'b00, 16'h0F0F, 16'h0101, 16'h1010, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
